// File: rtl/puf_ctrl_pkg.sv
// rtl/puf_ctrl_pkg.sv - shared state encoding, defaults and width helpers for the arbiter PUF controller
package puf_ctrl_pkg;

    localparam int C_LENGTH_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_FIRE,
        ST_SAMPLE,
        ST_RESOLVE,
        ST_DONE
    } puf_state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/puf_resp_sync.sv
// rtl/puf_resp_sync.sv - two-flop synchronizer for the asynchronous arbiter response
module puf_resp_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// rtl/puf_challenge_sequencer.sv - walks a challenge run, fires the PUF race, majority-votes and packs responses
module puf_challenge_sequencer
    import puf_ctrl_pkg::*;
#(
    parameter int C_LENGTH  = C_LENGTH_DEF,
    parameter int RESP_BITS = 8,
    parameter int VOTES     = 3,
    parameter int SETTLE    = 2,
    parameter int HOLD      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [C_LENGTH-1:0]  base_challenge,
    output logic                 busy,
    output logic [C_LENGTH-1:0]  puf_challenge,
    output logic                 puf_pulse,
    input  logic                 puf_response,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RESP_BITS-1:0] out_data,
    output logic [RESP_BITS-1:0] out_unstable
);

    localparam int VW = cnt_width(VOTES + 1);
    localparam int BW = cnt_width(RESP_BITS);
    localparam int PW = cnt_width((SETTLE > HOLD) ? SETTLE : HOLD);

    puf_state_t     state;
    logic [PW-1:0]  phase;
    logic [VW-1:0]  vote_cnt;
    logic [VW-1:0]  ones;
    logic [BW-1:0]  bit_idx;
    logic           resp_sync;

    puf_resp_sync u_resp_sync (
        .clk (clk),
        .rst (rst),
        .d   (puf_response),
        .q   (resp_sync)
    );

    // puf_pulse is set/cleared on the edges entering/leaving FIRE so it is high exactly HOLD cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            phase         <= '0;
            vote_cnt      <= '0;
            ones          <= '0;
            bit_idx       <= '0;
            busy          <= 1'b0;
            puf_challenge <= '0;
            puf_pulse     <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_unstable  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        puf_challenge <= base_challenge;
                        bit_idx       <= '0;
                        vote_cnt      <= '0;
                        ones          <= '0;
                        phase         <= '0;
                        busy          <= 1'b1;
                        state         <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (phase == PW'(SETTLE - 1)) begin
                        phase     <= '0;
                        puf_pulse <= 1'b1;
                        state     <= ST_FIRE;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                ST_FIRE: begin
                    if (phase == PW'(HOLD - 1)) begin
                        phase     <= '0;
                        puf_pulse <= 1'b0;
                        state     <= ST_SAMPLE;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                ST_SAMPLE: begin
                    ones <= ones + VW'(resp_sync);
                    if (vote_cnt == VW'(VOTES - 1)) begin
                        state <= ST_RESOLVE;
                    end else begin
                        vote_cnt <= vote_cnt + VW'(1);
                        state    <= ST_SETTLE;
                    end
                end
                ST_RESOLVE: begin
                    out_data[bit_idx]     <= (ones > VW'(VOTES / 2));
                    out_unstable[bit_idx] <= (ones != '0) && (ones != VW'(VOTES));
                    vote_cnt              <= '0;
                    ones                  <= '0;
                    puf_challenge         <= puf_challenge + C_LENGTH'(1);
                    if (bit_idx == BW'(RESP_BITS - 1)) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        bit_idx <= bit_idx + BW'(1);
                        state   <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb/tb_puf_challenge_sequencer.sv - directed and randomized bench with a behavioural PUF and result model
module tb_puf_challenge_sequencer;

    localparam int NV  = 3;
    localparam int HD  = 2;
    localparam int LAT = 8 * (NV * (2 + HD + 1) + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_challenge = 8'h00;
    logic        busy;
    logic [7:0]  puf_challenge;
    logic        puf_pulse;
    logic        puf_response = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [7:0]  out_unstable;

    int errors = 0;
    int checks = 0;

    logic [255:0] lut = '0;
    logic         flip_mask [0:1023];
    logic [7:0]   chal_log  [0:1023];
    int           fire_cnt = 0;

    int   hi_cnt = 0, run_len = 0, width_err = 0, chal_err = 0;
    logic prev_pulse = 1'b0;
    logic [7:0] prev_chal = 8'h00;

    puf_challenge_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_challenge (base_challenge),
        .busy           (busy),
        .puf_challenge  (puf_challenge),
        .puf_pulse      (puf_pulse),
        .puf_response   (puf_response),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_unstable   (out_unstable)
    );

    always #5 clk = ~clk;

    // Behavioural arbiter: the race result settles shortly after the launch edge.
    always @(posedge puf_pulse) begin
        #1;
        chal_log[fire_cnt % 1024] = puf_challenge;
        puf_response = lut[puf_challenge] ^ flip_mask[fire_cnt % 1024];
        fire_cnt = fire_cnt + 1;
    end

    always @(negedge clk) begin
        if (puf_pulse === 1'b1) begin
            hi_cnt  = hi_cnt + 1;
            run_len = run_len + 1;
            if (prev_pulse === 1'b1 && puf_challenge !== prev_chal) chal_err = chal_err + 1;
        end else begin
            if (prev_pulse === 1'b1 && run_len != HD) width_err = width_err + 1;
            run_len = 0;
        end
        prev_pulse = puf_pulse;
        prev_chal  = puf_challenge;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected word: majority of the three noisy evaluations of f(base+k).
    task automatic model(input logic [7:0] b, input int fb, output logic [7:0] ed, output logic [7:0] eu);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] c;
            int n1;
            c  = b + 8'(k);
            n1 = 0;
            for (int v = 0; v < NV; v++) n1 += int'(lut[c] ^ flip_mask[(fb + k * NV + v) % 1024]);
            ed[k] = (n1 * 2 > NV);
            eu[k] = (n1 != 0) && (n1 != NV);
        end
    endtask

    task automatic launch(input logic [7:0] b, output int fb);
        @(negedge clk);
        base_challenge = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fb = fire_cnt;
    endtask

    task automatic set_flips(input int fb, input logic [23:0] m);
        for (int j = 0; j < 24; j++) flip_mask[(fb + j) % 1024] = m[j];
    endtask

    task automatic finish_run(input string tag, input logic [7:0] b, input int fb);
        int lat;
        int bad;
        logic [7:0] ed, eu;
        lat = 0;
        bad = 0;
        check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
        while (out_valid !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, LAT);
        model(b, fb, ed, eu);
        check({tag, "_data"}, {24'd0, out_data}, {24'd0, ed});
        check({tag, "_unstable"}, {24'd0, out_unstable}, {24'd0, eu});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        for (int k = 0; k < 8; k++)
            for (int v = 0; v < NV; v++)
                if (chal_log[(fb + k * NV + v) % 1024] !== b + 8'(k)) bad++;
        check({tag, "_chal_order"}, bad, 0);
    endtask

    task automatic accept_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_clear"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int fb, hi0, w0, c0, bad, wt;
        logic [7:0] held;

        for (int i = 0; i < 1024; i++) begin
            flip_mask[i] = 1'b0;
            chal_log[i]  = 8'h00;
        end

        // Reset, idle, reset again mid-idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_outputs", {busy, puf_pulse, out_valid, puf_challenge, out_data, out_unstable}, 32'd0);
        rst = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0 || puf_pulse !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);

        // f = challenge[0] from base 0
        lut = {128{2'b10}};
        hi0 = hi_cnt; w0 = width_err; c0 = chal_err;
        launch(8'h00, fb);
        set_flips(fb, 24'h0);
        finish_run("parity", 8'h00, fb);
        check("parity_const", {24'd0, out_data}, 32'hAA);
        check("parity_firings", fire_cnt - fb, 24);
        check("parity_high_cycles", hi_cnt - hi0, 48);
        check("parity_width", width_err - w0, 0);
        check("parity_chal_stable", chal_err - c0, 0);
        accept_out("parity");

        // Challenge wrap
        lut = '0;
        lut[255] = 1'b1;
        launch(8'hFC, fb);
        set_flips(fb, 24'h0);
        finish_run("wrap", 8'hFC, fb);
        check("wrap_const", {out_unstable, out_data}, 32'h0008);
        accept_out("wrap");

        // One then two dissenting votes on base+2
        lut = '1;
        launch(8'h10, fb);
        set_flips(fb, 24'h000040);
        finish_run("noise1", 8'h10, fb);
        check("noise1_const", {out_unstable, out_data}, 32'h04FF);
        accept_out("noise1");
        launch(8'h20, fb);
        set_flips(fb, 24'h0000C0);
        finish_run("noise2", 8'h20, fb);
        check("noise2_const", {out_unstable, out_data}, 32'h04FB);
        accept_out("noise2");

        // Backpressure with a stray start while DONE
        lut = {8{$urandom()}};
        launch(8'h5A, fb);
        set_flips(fb, 24'h0);
        finish_run("bp", 8'h5A, fb);
        held = out_data;
        wt = fire_cnt;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            base_challenge = 8'h33;
            start = (i == 3);
            @(negedge clk);
            if (out_data !== held || out_valid !== 1'b1 || busy !== 1'b0) bad++;
        end
        start = 1'b0;
        check("bp_hold", bad, 0);
        check("bp_no_fire", fire_cnt - wt, 0);
        out_ready = 1'b1;
        start = 1'b1;
        base_challenge = 8'h77;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_start_ignored", {30'd0, out_valid, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        fb = fire_cnt;
        set_flips(fb, 24'h0);
        finish_run("bp_next", 8'h77, fb);
        accept_out("bp_next");

        // Reset during the second firing of bit 3
        lut = {128{2'b10}};
        launch(8'h00, fb);
        set_flips(fb, 24'h0);
        wt = 0;
        while (fire_cnt < fb + 11 && wt < 500) begin
            @(negedge clk);
            wt++;
        end
        check("midrst_reached", {31'd0, puf_pulse}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", {busy, puf_pulse, out_valid, out_data}, 32'd0);
        rst = 1'b0;
        launch(8'h00, fb);
        set_flips(fb, 24'h0);
        finish_run("after_rst", 8'h00, fb);
        check("after_rst_const", {out_unstable, out_data}, 32'h00AA);
        accept_out("after_rst");

        // Randomized runs: random PUF function, base and sparse vote noise
        for (int r = 0; r < 5; r++) begin
            logic [23:0] m;
            lut = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            launch(8'($urandom()), fb);
            for (int j = 0; j < 24; j++) m[j] = ($urandom_range(3) == 0);
            set_flips(fb, m);
            finish_run($sformatf("rand%0d", r), base_challenge, fb);
            accept_out($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
